// File: rtl/product_block_reader_if.sv
// Block-read handshake between the multiplier's product memory and its reader.
// master = the reader that requests and absorbs the beats; slave = the producer.
interface product_block_reader_if;
  logic        EN_blockRead;
  logic        VALID_memVal;
  logic [15:0] memVal_data;

  modport master (output EN_blockRead, input VALID_memVal, input memVal_data);
  modport slave  (input EN_blockRead, output VALID_memVal, output memVal_data);
endinterface

// File: rtl/product_block_reader.sv
// Drains one block from the multiplier on request and reduces it to
// sum/max/min/count, flagging timeout, short-block and overrun conditions.
module product_block_reader #(
  parameter  int BLOCK_LEN = 64,
  parameter  int TIMEOUT   = 16,
  localparam int LW        = $clog2(BLOCK_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  product_block_reader_if.master mem,
  output logic                   busy,
  output logic                   done,
  output logic [16+LW-1:0]       sum,
  output logic [15:0]            max_val,
  output logic [15:0]            min_val,
  output logic [LW:0]            beat_cnt,
  output logic                   short_block,
  output logic                   timeout_err,
  output logic                   overrun_err
);

  localparam int SW = 16 + LW;
  localparam int CW = LW + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(BLOCK_LEN - 1);
  localparam logic [CW-1:0] BEAT_FULL = CW'(BLOCK_LEN);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t          state, state_next;
  logic [WW-1:0]   wait_cnt;
  logic            en_q;
  logic            clear, accept, set_timeout, set_short, set_overrun;

  assign mem.EN_blockRead = en_q;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    state_next  = state;
    clear       = 1'b0;
    accept      = 1'b0;
    set_timeout = 1'b0;
    set_short   = 1'b0;
    set_overrun = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = REQ;
          clear      = 1'b1;
        end
        set_overrun = mem.VALID_memVal;
      end
      REQ: begin
        if (mem.VALID_memVal) begin
          accept     = 1'b1;
          state_next = RECV;
        end else if (wait_cnt == WAIT_LAST) begin
          set_timeout = 1'b1;
          state_next  = DONE;
        end
      end
      RECV: begin
        if (mem.VALID_memVal) begin
          accept = 1'b1;
          if (beat_cnt == BEAT_LAST) state_next = DONE;
        end else begin
          // A single bubble ends the block; the producer must burst back-to-back.
          state_next = DONE;
          set_short  = (beat_cnt < BEAT_FULL);
        end
      end
      DONE: begin
        state_next  = IDLE;
        set_overrun = mem.VALID_memVal;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      en_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sum         <= '0;
      max_val     <= '0;
      min_val     <= '0;
      beat_cnt    <= '0;
      short_block <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state <= state_next;
      en_q  <= (state_next == REQ);
      busy  <= (state_next == REQ) || (state_next == RECV);
      done  <= (state_next == DONE);

      if (state == REQ) wait_cnt <= wait_cnt + WW'(1);

      if (clear) begin
        wait_cnt    <= '0;
        sum         <= '0;
        beat_cnt    <= '0;
        max_val     <= '0;
        min_val     <= 16'hFFFF;
        short_block <= 1'b0;
        timeout_err <= 1'b0;
        overrun_err <= 1'b0;
      end

      if (accept) begin
        sum      <= sum + SW'(mem.memVal_data);
        beat_cnt <= beat_cnt + CW'(1);
        if (mem.memVal_data > max_val) max_val <= mem.memVal_data;
        if (mem.memVal_data < min_val) min_val <= mem.memVal_data;
      end

      if (set_timeout) timeout_err <= 1'b1;
      if (set_short)   short_block <= 1'b1;
      // Placed after the clear so a beat coinciding with an accepted start still flags.
      if (set_overrun) overrun_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_product_block_reader.sv
// Directed bench for product_block_reader: one task per scenario, expected
// values hand-computed from the block's documented behaviour.
module tb_product_block_reader;
  localparam int BLOCK_LEN = 64;
  localparam int TIMEOUT   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, short_block, timeout_err, overrun_err;
  logic [21:0] sum;
  logic [15:0] max_val, min_val;
  logic [6:0]  beat_cnt;

  int checks = 0;
  int errors = 0;

  product_block_reader_if mem ();

  product_block_reader #(.BLOCK_LEN(BLOCK_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mem(mem.master),
    .busy(busy), .done(done), .sum(sum), .max_val(max_val), .min_val(min_val),
    .beat_cnt(beat_cnt), .short_block(short_block), .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem.VALID_memVal = 1'b0;
    mem.memVal_data  = 16'h0;
  endtask

  task automatic do_start();
    idle_in();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d);
    mem.VALID_memVal = 1'b1;
    mem.memVal_data  = d;
    tick();
  endtask

  task automatic wait_idle(input string name);
    idle_in();
    for (int i = 0; i < 40; i++) begin
      if (!busy && !done) break;
      tick();
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_wait_idle: busy=%b done=%b, required busy=0 done=0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    idle_in();
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if ({mem.EN_blockRead, busy, done, sum, max_val, min_val, beat_cnt, short_block, timeout_err, overrun_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b busy=%b done=%b sum=%0d max=%h min=%h cnt=%0d flags=%b%b%b, required all 0",
               mem.EN_blockRead, busy, done, sum, max_val, min_val, beat_cnt, short_block, timeout_err, overrun_err);
    end
  endtask

  task automatic test_full_burst();
    logic [21:0] exp_sum;
    exp_sum = '0;
    do_start();
    checks++;
    if ({mem.EN_blockRead, busy, beat_cnt, min_val} !== {1'b1, 1'b1, 7'd0, 16'hFFFF}) begin
      errors++;
      $display("FAIL full_req_entry: en=%b busy=%b cnt=%0d min=%h, required en=1 busy=1 cnt=0 min=ffff",
               mem.EN_blockRead, busy, beat_cnt, min_val);
    end
    for (int i = 1; i <= BLOCK_LEN; i++) begin
      beat(16'(i));
      exp_sum += 22'(i);
      checks++;
      if ({sum, beat_cnt, mem.EN_blockRead, done} !== {exp_sum, 7'(i), 1'b0, (i == BLOCK_LEN)}) begin
        errors++;
        $display("FAIL full_beat_%0d: sum=%0d cnt=%0d en=%b done=%b, required sum=%0d cnt=%0d en=0 done=%b",
                 i, sum, beat_cnt, mem.EN_blockRead, done, exp_sum, i, (i == BLOCK_LEN));
      end
    end
    idle_in();
    checks++;
    if ({max_val, min_val, short_block, timeout_err, overrun_err, busy} !== {16'd64, 16'd1, 4'b0000}) begin
      errors++;
      $display("FAIL full_result: max=%0d min=%0d short=%b to=%b ovr=%b busy=%b, required max=64 min=1 flags=0 busy=0",
               max_val, min_val, short_block, timeout_err, overrun_err, busy);
    end
    tick();
    checks++;
    if ({done, sum} !== {1'b0, 22'd2080}) begin
      errors++;
      $display("FAIL full_after_done: done=%b sum=%0d, required done=0 sum=2080", done, sum);
    end
  endtask

  task automatic test_short_burst();
    do_start();
    for (int i = 0; i < 10; i++) beat(16'hFFFF);
    idle_in();
    checks++;
    if ({done, busy, beat_cnt} !== {1'b0, 1'b1, 7'd10}) begin
      errors++;
      $display("FAIL short_k_plus_10: done=%b busy=%b cnt=%0d, required done=0 busy=1 cnt=10", done, busy, beat_cnt);
    end
    tick();
    checks++;
    if ({done, sum, beat_cnt, max_val, min_val, short_block} !== {1'b1, 22'd655350, 7'd10, 16'hFFFF, 16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL short_result: done=%b sum=%0d cnt=%0d max=%h min=%h short=%b, required 1 655350 10 ffff ffff 1",
               done, sum, beat_cnt, max_val, min_val, short_block);
    end
    wait_idle("short");
  endtask

  task automatic test_timeout();
    do_start();
    for (int c = 1; c <= TIMEOUT; c++) begin
      checks++;
      if ({mem.EN_blockRead, done, busy} !== 3'b101) begin
        errors++;
        $display("FAIL timeout_req_cycle_%0d: en=%b done=%b busy=%b, required en=1 done=0 busy=1",
                 c, mem.EN_blockRead, done, busy);
      end
      tick();
    end
    checks++;
    if ({mem.EN_blockRead, done, timeout_err, short_block, beat_cnt, sum, min_val, max_val}
        !== {1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 22'd0, 16'hFFFF, 16'd0}) begin
      errors++;
      $display("FAIL timeout_result: en=%b done=%b to=%b short=%b cnt=%0d sum=%0d min=%h max=%h, required 0 1 1 0 0 0 ffff 0",
               mem.EN_blockRead, done, timeout_err, short_block, beat_cnt, sum, min_val, max_val);
    end
    wait_idle("timeout");
  endtask

  task automatic test_overrun();
    do_start();
    for (int i = 1; i <= BLOCK_LEN; i++) beat(16'(i));
    checks++;
    if ({done, overrun_err} !== 2'b10) begin
      errors++;
      $display("FAIL overrun_done_cycle: done=%b ovr=%b, required done=1 ovr=0", done, overrun_err);
    end
    beat(16'd65);
    idle_in();
    checks++;
    if ({overrun_err, sum, beat_cnt, max_val} !== {1'b1, 22'd2080, 7'd64, 16'd64}) begin
      errors++;
      $display("FAIL overrun_flag: ovr=%b sum=%0d cnt=%0d max=%0d, required ovr=1 sum=2080 cnt=64 max=64",
               overrun_err, sum, beat_cnt, max_val);
    end
    repeat (3) tick();
    checks++;
    if (overrun_err !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: ovr=%b, required 1", overrun_err);
    end
    do_start();
    checks++;
    if ({overrun_err, sum, max_val, min_val} !== {1'b0, 22'd0, 16'd0, 16'hFFFF}) begin
      errors++;
      $display("FAIL overrun_clear_on_start: ovr=%b sum=%0d max=%h min=%h, required 0 0 0 ffff",
               overrun_err, sum, max_val, min_val);
    end
    wait_idle("overrun");
  endtask

  task automatic test_worst_case_sum();
    do_start();
    for (int i = 0; i < BLOCK_LEN; i++) beat(16'hFFFF);
    idle_in();
    checks++;
    if ({done, sum, beat_cnt, short_block, min_val} !== {1'b1, 22'd4194240, 7'd64, 1'b0, 16'hFFFF}) begin
      errors++;
      $display("FAIL worst_sum: done=%b sum=%0d cnt=%0d short=%b min=%h, required 1 4194240 64 0 ffff",
               done, sum, beat_cnt, short_block, min_val);
    end
    wait_idle("worst");
  endtask

  task automatic test_start_with_valid();
    start = 1'b1;
    mem.VALID_memVal = 1'b1;
    mem.memVal_data  = 16'd5;
    tick();
    start = 1'b0;
    idle_in();
    checks++;
    if ({overrun_err, busy, mem.EN_blockRead, beat_cnt, sum} !== {1'b1, 1'b1, 1'b1, 7'd0, 22'd0}) begin
      errors++;
      $display("FAIL start_with_valid: ovr=%b busy=%b en=%b cnt=%0d sum=%0d, required 1 1 1 0 0",
               overrun_err, busy, mem.EN_blockRead, beat_cnt, sum);
    end
    wait_idle("start_valid");
  endtask

  task automatic test_reset_mid_burst();
    do_start();
    for (int i = 1; i <= 29; i++) begin
      start = (i == 16);
      beat(16'(i));
      start = 1'b0;
    end
    checks++;
    if ({sum, beat_cnt, mem.EN_blockRead, busy, overrun_err} !== {22'd435, 7'd29, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ignored_start: sum=%0d cnt=%0d en=%b busy=%b ovr=%b, required 435 29 0 1 0",
               sum, beat_cnt, mem.EN_blockRead, busy, overrun_err);
    end
    rst = 1'b1;
    beat(16'd30);
    rst = 1'b0;
    checks++;
    if ({mem.EN_blockRead, busy, done, sum, max_val, min_val, beat_cnt, short_block, timeout_err, overrun_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid: en=%b busy=%b done=%b sum=%0d max=%h min=%h cnt=%0d flags=%b%b%b, required all 0",
               mem.EN_blockRead, busy, done, sum, max_val, min_val, beat_cnt, short_block, timeout_err, overrun_err);
    end
    beat(16'd31);
    checks++;
    if ({overrun_err, busy, sum} !== {1'b1, 1'b0, 22'd0}) begin
      errors++;
      $display("FAIL reset_mid_overrun: ovr=%b busy=%b sum=%0d, required 1 0 0", overrun_err, busy, sum);
    end
    for (int i = 32; i <= BLOCK_LEN; i++) beat(16'(i));
    idle_in();
    tick();
    do_start();
    for (int i = 1; i <= BLOCK_LEN; i++) beat(16'(i));
    idle_in();
    checks++;
    if ({done, sum, beat_cnt, max_val, min_val, overrun_err, short_block}
        !== {1'b1, 22'd2080, 7'd64, 16'd64, 16'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_block: done=%b sum=%0d cnt=%0d max=%0d min=%0d ovr=%b short=%b, required 1 2080 64 64 1 0 0",
               done, sum, beat_cnt, max_val, min_val, overrun_err, short_block);
    end
    wait_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_short_burst();
    test_timeout();
    test_overrun();
    test_worst_case_sum();
    test_start_with_valid();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_block_reader.md
# product_block_reader

Consumer end of the multiplier's block-read interface. On a start request it raises `EN_blockRead`, absorbs the resulting burst of `VALID_memVal`/`memVal_data` beats, and reduces the block to a sum, maximum, minimum and beat count. It also flags timeout, short-block and overrun conditions. It sits between the multiplier/product-memory subsystem and the downstream result logic.

## Interface
- `BLOCK_LEN`, default 64: expected beats per block. Power of two, at least 2.
- `TIMEOUT`, default 16: cycles to wait in REQ for the first beat.
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: request a block drain. Accepted only in IDLE.
- `EN_blockRead`  out  1: block-read request to the multiplier.
- `VALID_memVal`  in  1: beat valid.
- `memVal_data`  in  16: beat data, unsigned.
- `busy`  out  1: high in REQ or RECV.
- `done`  out  1: one-cycle pulse in DONE.
- `sum`  out  16+log2(BLOCK_LEN) (22): unsigned sum of the beats.
- `max_val`  out  16: largest beat.
- `min_val`  out  16: smallest beat.
- `beat_cnt`  out  log2(BLOCK_LEN)+1 (7): beats received.
- `short_block`  out  1: block ended with fewer than BLOCK_LEN beats.
- `timeout_err`  out  1: no beat arrived within TIMEOUT cycles.
- `overrun_err`  out  1: a beat arrived while not receiving. Sticky.

## Operation
- All outputs are registered.
- Reset value of every output is 0. State after reset is IDLE.
- **IDLE:** `EN_blockRead`=0 and `busy`=0.
  - On `start`=1 the block moves to REQ.
  - On entry to REQ it clears `sum`, `beat_cnt`, `short_block`, `timeout_err`, `overrun_err` and the wait counter.
  - It sets `max_val`=0 and `min_val`=16'hFFFF.
- **REQ:** `EN_blockRead`=1 and `busy`=1. The wait counter increments each cycle.
  - If `VALID_memVal`=1, the block accumulates the beat and moves to RECV.
  - If the wait counter reaches TIMEOUT with no beat, the block sets `timeout_err` and moves to DONE.
- **RECV:** `EN_blockRead`=0 and `busy`=1.
  - Each cycle with `VALID_memVal`=1 accumulates the beat.
  - After a beat, if `beat_cnt` has reached BLOCK_LEN, the block moves to DONE.
  - If `VALID_memVal`=0, the block moves to DONE and sets `short_block` when `beat_cnt` < BLOCK_LEN.
- **DONE:** `done`=1 for exactly one cycle, then the block returns to IDLE.
  - Results hold until the next accepted `start`.
- **Accumulate** means, in one edge:
  - `sum` += `memVal_data`, zero-extended. It cannot overflow at 22 bits.
  - `beat_cnt` += 1.
  - `max_val` = max(`max_val`, data) and `min_val` = min(`min_val`, data).
- **Overrun:** `VALID_memVal`=1 while in IDLE or DONE sets `overrun_err`. This includes beat BLOCK_LEN+1 of an over-long burst. The beat is not accumulated, and the flag clears only on an accepted `start`.
- **Ignored start:** `start` in REQ, RECV or DONE is ignored and not queued.
- **Start with valid:** if `start` and `VALID_memVal` are both high in IDLE, the block accepts the start and flags overrun for that beat. Clearing happens first, then the flag is set.
- **Zero beats:** if the block ends with no beats (timeout), `min_val` remains 16'hFFFF and `max_val` remains 0.
- **Reset mid-operation:** any state returns to IDLE with all outputs 0. `EN_blockRead` is low from the cycle after the `rst` edge.

## Timing
- `start` is sampled at edge t. `EN_blockRead` and `busy` are high from cycle t+1.
- **Accumulate latency:** a beat sampled at an edge appears in `sum`, `beat_cnt`, `max_val` and `min_val` in the following cycle.
- **EN_blockRead deassertion:** the signal drops in the cycle after the first beat is sampled. It is high for at most TIMEOUT cycles.
- **Full burst:** beats occupy cycles k..k+BLOCK_LEN-1. `done` is high in cycle k+BLOCK_LEN.
- **Short burst:** with n beats in cycles k..k+n-1, `VALID_memVal` is sampled low at k+n. `done` is high in cycle k+n+1.
- **Timeout:** with `start` at cycle 0 and REQ in cycles 1..TIMEOUT, `done` is high in cycle TIMEOUT+1.
- **Bubbles:** one bubble in RECV ends the block. The producer must burst back-to-back.

## Test plan
- **Full burst:** start, then 64 back-to-back beats of values 1..64 starting cycle k.
  - Expect `sum`=2080, `max_val`=64, `min_val`=1, `beat_cnt`=64, `short_block`=0.
  - Expect `done` only in cycle k+64 and `EN_blockRead` high for exactly the cycles up to and including k.
- **Short burst:** 10 beats of 16'hFFFF, then `VALID_memVal` low.
  - Expect `sum`=655350, `beat_cnt`=10, `max_val`=`min_val`=16'hFFFF, `short_block`=1, `done` in cycle k+11.
- **Timeout:** start, `VALID_memVal` never asserted.
  - Expect `EN_blockRead` high in cycles 1..16, then `done` and `timeout_err`=1 in cycle 17.
  - Expect `beat_cnt`=0, `min_val`=16'hFFFF, `max_val`=0.
- **Overrun:** 65-beat burst.
  - Expect the first 64 beats accumulated and `overrun_err`=1 from the cycle after beat 65.
  - Expect `overrun_err` to clear on the next accepted `start`.
- **Worst-case sum:** 64 beats of 16'hFFFF.
  - Expect `sum`=4194240 with no wrap.
- **Reset and start-while-busy:** pulse `start` during RECV and expect no effect. Assert `rst` at beat 30 of a burst.
  - Expect all outputs 0 and IDLE next cycle.
  - Expect the remaining beats to set `overrun_err`.
  - Expect a following start/64-beat block to complete normally.
